// File: rtl/eth_rx_ctrl_pkg.sv
// Shared types and constants for the frame-aligned RX enable controller.
package eth_rx_ctrl_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    WAIT_IDLE = 2'd1,
    ENABLED   = 2'd2,
    DRAIN     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/eth_rx_ctrl_if.sv
// Receiver-side signals the controller monitors, plus the enable it returns.
interface eth_rx_ctrl_if;

  logic gmii_rx_dv;
  logic clk_enable;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tuser;
  logic start_packet;
  logic error_bad_fcs;
  logic cfg_rx_enable;

  modport master (
    output gmii_rx_dv, clk_enable, m_axis_tvalid, m_axis_tlast,
           m_axis_tuser, start_packet, error_bad_fcs,
    input  cfg_rx_enable
  );

  modport slave (
    input  gmii_rx_dv, clk_enable, m_axis_tvalid, m_axis_tlast,
           m_axis_tuser, start_packet, error_bad_fcs,
    output cfg_rx_enable
  );

endinterface

// File: rtl/eth_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module eth_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_rx_ctrl.sv
// Frame-aligned receive-enable controller with saturating per-frame statistics.
// Define ETH_RX_CTRL_STATS_EN to build the statistics and length counters.
module eth_rx_ctrl
  import eth_rx_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES   = 12,
  parameter int MAX_LEN       = 1518,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rx_enable,
  input  logic                   stat_clear,
  eth_rx_ctrl_if.slave           rx,
  output logic                   rx_enabled,
  output logic                   drain_timeout,
  output logic [COUNT_WIDTH-1:0] frames_good,
  output logic [COUNT_WIDTH-1:0] frames_bad,
  output logic [COUNT_WIDTH-1:0] fcs_errors,
  output logic [COUNT_WIDTH-1:0] frames_oversize
);

  localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
  localparam int DRAIN_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  rx_state_e          state;
  rx_state_e          state_nxt;
  logic               timeout_nxt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_entry;
  logic               in_frame;
  logic               frame_last;

  assign frame_last = rx.m_axis_tvalid & rx.m_axis_tlast;

  // Idle run only counts while waiting to enable, so it measures quiet line time since the request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != WAIT_IDLE) begin
      idle_cnt <= '0;
    end else if (rx.clk_enable) begin
      if (rx.gmii_rx_dv) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_frame <= 1'b0;
    end else if (frame_last) begin
      in_frame <= 1'b0;
    end else if (rx.start_packet) begin
      in_frame <= 1'b1;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    case (state)
      DISABLED: begin
        if (sw_rx_enable) state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!sw_rx_enable)           state_nxt = DISABLED;
        else if (idle_cnt == IDLE_MAX) state_nxt = ENABLED;
      end
      ENABLED: begin
        if (!sw_rx_enable) state_nxt = (in_frame || rx.start_packet) ? DRAIN : DISABLED;
      end
      DRAIN: begin
        if (sw_rx_enable) begin
          state_nxt = ENABLED;
        end else if (frame_last) begin
          state_nxt = DISABLED;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt   = DISABLED;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = DISABLED;
    endcase
  end

  assign drain_entry = (state_nxt == DRAIN) && (state != DRAIN);

  eth_sat_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == DRAIN),
    .clr   (drain_entry),
    .count (drain_cnt)
  );

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= DISABLED;
      rx.cfg_rx_enable <= 1'b0;
      rx_enabled       <= 1'b0;
      drain_timeout    <= 1'b0;
    end else begin
      state            <= state_nxt;
      rx.cfg_rx_enable <= (state_nxt == ENABLED) || (state_nxt == DRAIN);
      rx_enabled       <= (state_nxt == ENABLED) || (state_nxt == DRAIN);
      drain_timeout    <= timeout_nxt;
    end
  end

`ifdef ETH_RX_CTRL_STATS_EN
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_beat;
  logic             frame_done;

  assign len_beat = (len_cnt == '1) ? len_cnt : len_cnt + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_cnt <= '0;
    end else if (frame_last) begin
      len_cnt <= '0;
    end else if (rx.m_axis_tvalid && (len_cnt != '1)) begin
      len_cnt <= len_cnt + LEN_W'(1);
    end
  end

  // A tail whose start was lost to reset is not a tracked frame and is not counted.
  assign frame_done = frame_last & (in_frame | rx.start_packet);

  eth_sat_counter #(.WIDTH(COUNT_WIDTH)) u_good (
    .clk(clk), .rst_n(rst_n), .inc(frame_done & ~rx.m_axis_tuser),
    .clr(stat_clear), .count(frames_good)
  );

  eth_sat_counter #(.WIDTH(COUNT_WIDTH)) u_bad (
    .clk(clk), .rst_n(rst_n), .inc(frame_done & rx.m_axis_tuser),
    .clr(stat_clear), .count(frames_bad)
  );

  eth_sat_counter #(.WIDTH(COUNT_WIDTH)) u_fcs (
    .clk(clk), .rst_n(rst_n), .inc(rx.error_bad_fcs),
    .clr(stat_clear), .count(fcs_errors)
  );

  eth_sat_counter #(.WIDTH(COUNT_WIDTH)) u_oversize (
    .clk(clk), .rst_n(rst_n), .inc(frame_done & (int'(len_beat) > MAX_LEN)),
    .clr(stat_clear), .count(frames_oversize)
  );
`else
  logic unused_stats;
  assign unused_stats    = ^{stat_clear, rx.m_axis_tuser, rx.error_bad_fcs};
  assign frames_good     = '0;
  assign frames_bad      = '0;
  assign fcs_errors      = '0;
  assign frames_oversize = '0;
`endif

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Self-checking bench for eth_rx_ctrl: FSM timing checks plus a statistics scoreboard.
// Statistics expectations follow ETH_RX_CTRL_STATS_EN (all zero when it is undefined).
module tb_eth_rx_ctrl;

  localparam int IDLE_CYCLES   = 12;
  localparam int MAX_LEN       = 1518;
  localparam int DRAIN_TIMEOUT = 16;
  localparam int CW            = 2;

  typedef struct packed {
    logic [CW-1:0] good;
    logic [CW-1:0] bad;
    logic [CW-1:0] fcs;
    logic [CW-1:0] over;
  } stats_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_rx_enable;
  logic          stat_clear;
  logic          rx_enabled;
  logic          drain_timeout;
  logic [CW-1:0] frames_good;
  logic [CW-1:0] frames_bad;
  logic [CW-1:0] fcs_errors;
  logic [CW-1:0] frames_oversize;

  int     vectors     = 0;
  int     miscompares = 0;
  stats_t model       = '0;
  stats_t exp_q[$];

  eth_rx_ctrl_if rx_if ();

  eth_rx_ctrl #(
    .IDLE_CYCLES   (IDLE_CYCLES),
    .MAX_LEN       (MAX_LEN),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sw_rx_enable    (sw_rx_enable),
    .stat_clear      (stat_clear),
    .rx              (rx_if),
    .rx_enabled      (rx_enabled),
    .drain_timeout   (drain_timeout),
    .frames_good     (frames_good),
    .frames_bad      (frames_bad),
    .fcs_errors      (fcs_errors),
    .frames_oversize (frames_oversize)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic stats_t dut_stats();
    return {frames_good, frames_bad, fcs_errors, frames_oversize};
  endfunction

  // Scoreboard model: update on stimulus, push the expected counter snapshot.
  function automatic void model_frame(input int len, input bit user, input bit fcs, input bit clr);
    stats_t n;
    n = model;
    if (clr) begin
      n = '0;
    end else begin
      if (user) n.bad = sat_inc(n.bad);
      else      n.good = sat_inc(n.good);
      if (fcs) n.fcs = sat_inc(n.fcs);
      if (len > MAX_LEN) n.over = sat_inc(n.over);
    end
`ifdef ETH_RX_CTRL_STATS_EN
    model = n;
`endif
    exp_q.push_back(model);
  endfunction

  task automatic idle_bus();
    rx_if.m_axis_tvalid = 1'b0;
    rx_if.m_axis_tlast  = 1'b0;
    rx_if.m_axis_tuser  = 1'b0;
    rx_if.error_bad_fcs = 1'b0;
    rx_if.start_packet  = 1'b0;
    stat_clear          = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the tlast beat.
  task automatic send_frame(input int len, input bit user, input bit fcs, input bit clr_last);
    model_frame(len, user, fcs, clr_last);
    rx_if.start_packet = 1'b1;
    @(negedge clk);
    rx_if.start_packet = 1'b0;
    for (int i = 1; i <= len; i++) begin
      rx_if.m_axis_tvalid = 1'b1;
      rx_if.m_axis_tlast  = (i == len);
      rx_if.m_axis_tuser  = (i == len) && user;
      rx_if.error_bad_fcs = (i == len) && fcs;
      stat_clear          = (i == len) && clr_last;
      @(negedge clk);
    end
    idle_bus();
  endtask

  // Raises the request and counts negedges until cfg_rx_enable is seen (0 if never).
  task automatic request_enable(output int n_seen);
    n_seen = 0;
    sw_rx_enable = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rx_if.cfg_rx_enable === 1'b1) begin
        n_seen = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_if.cfg_rx_enable, rx_enabled, drain_timeout, dut_stats()} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cfg=%b en=%b to=%b stats=%h, want all 0",
               rx_if.cfg_rx_enable, rx_enabled, drain_timeout, dut_stats());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_enable();
    sw_rx_enable = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      vectors++;
      if (rx_if.cfg_rx_enable !== (i == 14) || rx_enabled !== (i == 14)) begin
        miscompares++;
        $display("FAIL idle_enable cycle %0d: got cfg=%b en=%b, want %b",
                 i, rx_if.cfg_rx_enable, rx_enabled, (i == 14));
      end
    end
    sw_rx_enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_if.cfg_rx_enable !== 1'b0 || rx_enabled !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_disable: got cfg=%b en=%b, want 0", rx_if.cfg_rx_enable, rx_enabled);
    end
  endtask

  task automatic test_busy_line();
    int waited;
    sw_rx_enable = 1'b1;
    for (int n = 0; n <= 24; n++) begin
      rx_if.gmii_rx_dv = (n % 6 == 0);
      @(negedge clk);
      vectors++;
      if (rx_if.cfg_rx_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_line step %0d: got cfg=%b, want 0", n, rx_if.cfg_rx_enable);
      end
    end
    // Quiet line from here, except three unqualified cycles with dv high that must not count.
    waited = 0;
    rx_if.gmii_rx_dv = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rx_if.cfg_rx_enable === 1'b1) begin
        waited = n;
        break;
      end
      rx_if.clk_enable = !(n >= 4 && n <= 6);
      rx_if.gmii_rx_dv = (n >= 4 && n <= 6);
    end
    rx_if.clk_enable = 1'b1;
    rx_if.gmii_rx_dv = 1'b0;
    vectors++;
    if (waited !== 16) begin
      miscompares++;
      $display("FAIL busy_line_enable: got enable after %0d cycles, want 16", waited);
    end
  endtask

  task automatic test_drain();
    stats_t exp_s;
    model_frame(64, 1'b0, 1'b0, 1'b0);
    rx_if.start_packet = 1'b1;
    @(negedge clk);
    rx_if.start_packet = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      rx_if.m_axis_tvalid = 1'b1;
      @(negedge clk);
    end
    rx_if.m_axis_tvalid = 1'b0;
    sw_rx_enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_if.cfg_rx_enable !== 1'b1 || rx_enabled !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_entry: got cfg=%b en=%b, want 1", rx_if.cfg_rx_enable, rx_enabled);
    end
    for (int b = 1; b <= 4; b++) begin
      rx_if.m_axis_tvalid = 1'b1;
      rx_if.m_axis_tlast  = (b == 4);
      @(negedge clk);
      vectors++;
      if (rx_if.cfg_rx_enable !== (b < 4) || rx_enabled !== (b < 4) || drain_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_beat %0d: got cfg=%b en=%b to=%b, want cfg=%b to=0",
                 b, rx_if.cfg_rx_enable, rx_enabled, drain_timeout, (b < 4));
      end
    end
    idle_bus();
    exp_s = exp_q.pop_front();
    vectors++;
    if (dut_stats() !== exp_s) begin
      miscompares++;
      $display("FAIL drain_stats: got %h, want %h", dut_stats(), exp_s);
    end
  endtask

  task automatic test_timeout();
    int     n_seen;
    int     pulse_at;
    stats_t exp_s;
    request_enable(n_seen);
    vectors++;
    if (n_seen !== 14) begin
      miscompares++;
      $display("FAIL timeout_enable: got enable after %0d cycles, want 14", n_seen);
    end
    rx_if.start_packet = 1'b1;
    @(negedge clk);
    rx_if.start_packet = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rx_if.m_axis_tvalid = 1'b1;
      @(negedge clk);
    end
    rx_if.m_axis_tvalid = 1'b0;
    sw_rx_enable = 1'b0;
    // DRAIN is entered at the next edge; the pulse should appear 16 edges after that.
    pulse_at = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (drain_timeout === 1'b1) begin
        pulse_at = n;
        break;
      end
    end
    vectors++;
    if (pulse_at !== 17 || rx_if.cfg_rx_enable !== 1'b0 || rx_enabled !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got pulse at %0d cfg=%b en=%b, want 17 cfg=0 en=0",
               pulse_at, rx_if.cfg_rx_enable, rx_enabled);
    end
    @(negedge clk);
    vectors++;
    if (drain_timeout !== 1'b0 || rx_if.cfg_rx_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_one_cycle: got to=%b cfg=%b, want 0", drain_timeout, rx_if.cfg_rx_enable);
    end
    // Closing the still-tracked frame counts it even though the controller is disabled.
    model_frame(6, 1'b0, 1'b0, 1'b0);
    rx_if.m_axis_tvalid = 1'b1;
    rx_if.m_axis_tlast  = 1'b1;
    @(negedge clk);
    idle_bus();
    exp_s = exp_q.pop_front();
    vectors++;
    if (dut_stats() !== exp_s) begin
      miscompares++;
      $display("FAIL timeout_tail_stats: got %h, want %h", dut_stats(), exp_s);
    end
  endtask

  task automatic test_stats();
    stats_t exp_s;
    int     lens[4]   = '{64, 1519, 100, 10};
    bit     users[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit     fcss[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit     clrs[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    model = '0;
    vectors++;
    if (dut_stats() !== model) begin
      miscompares++;
      $display("FAIL stats_clear: got %h, want %h", dut_stats(), model);
    end
    for (int f = 0; f < 4; f++) begin
      send_frame(lens[f], users[f], fcss[f], clrs[f]);
      exp_s = exp_q.pop_front();
      vectors++;
      if (dut_stats() !== exp_s) begin
        miscompares++;
        $display("FAIL stats_frame len=%0d user=%0d clr=%0d: got %h, want %h",
                 lens[f], users[f], clrs[f], dut_stats(), exp_s);
      end
    end
  endtask

  task automatic test_saturation();
    stats_t exp_s;
    int     lens[5] = '{1518, 4, 4, 4, 4};
    for (int f = 0; f < 5; f++) begin
      send_frame(lens[f], 1'b0, 1'b0, 1'b0);
      exp_s = exp_q.pop_front();
      vectors++;
      if (dut_stats() !== exp_s) begin
        miscompares++;
        $display("FAIL saturation frame %0d: got %h, want %h", f, dut_stats(), exp_s);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    int     n_seen;
    stats_t exp_s;
    request_enable(n_seen);
    vectors++;
    if (n_seen !== 14) begin
      miscompares++;
      $display("FAIL rst_drain_enable: got enable after %0d cycles, want 14", n_seen);
    end
    rx_if.start_packet = 1'b1;
    @(negedge clk);
    rx_if.start_packet = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rx_if.m_axis_tvalid = 1'b1;
      @(negedge clk);
    end
    rx_if.m_axis_tvalid = 1'b0;
    sw_rx_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rx_if.cfg_rx_enable, rx_enabled, drain_timeout, dut_stats()} !== '0) begin
      miscompares++;
      $display("FAIL rst_in_drain: got cfg=%b en=%b to=%b stats=%h, want all 0",
               rx_if.cfg_rx_enable, rx_enabled, drain_timeout, dut_stats());
    end
    rst_n = 1'b1;
    model = '0;
    // Tail of the abandoned frame: no start_packet since reset, so nothing is counted.
    exp_q.push_back(model);
    rx_if.m_axis_tvalid = 1'b1;
    @(negedge clk);
    rx_if.m_axis_tlast = 1'b1;
    @(negedge clk);
    idle_bus();
    exp_s = exp_q.pop_front();
    vectors++;
    if (dut_stats() !== exp_s) begin
      miscompares++;
      $display("FAIL abandoned_tail: got %h, want %h", dut_stats(), exp_s);
    end
    send_frame(8, 1'b0, 1'b0, 1'b0);
    exp_s = exp_q.pop_front();
    vectors++;
    if (dut_stats() !== exp_s) begin
      miscompares++;
      $display("FAIL post_reset_frame: got %h, want %h", dut_stats(), exp_s);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    sw_rx_enable        = 1'b0;
    stat_clear          = 1'b0;
    rx_if.gmii_rx_dv    = 1'b0;
    rx_if.clk_enable    = 1'b1;
    rx_if.m_axis_tvalid = 1'b0;
    rx_if.m_axis_tlast  = 1'b0;
    rx_if.m_axis_tuser  = 1'b0;
    rx_if.start_packet  = 1'b0;
    rx_if.error_bad_fcs = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_enable();
    test_busy_line();
    test_drain();
    test_timeout();
    test_stats();
    test_saturation();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
